// File: rtl/dp_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dp_ctrl_if : command and result handshake channels of dp_ctrl      |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
interface dp_ctrl_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_op;
   logic [1:0]  cmd_addr;
   logic [1:0]  cmd_instru;
   logic [15:0] cmd_data;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_instru, cmd_data, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_instru, cmd_data, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface
`default_nettype wire

// File: rtl/dp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dp_ctrl : command sequencer driving register bank / mux / ULA      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module dp_ctrl #(
   parameter int SETTLE_CYC = 1,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk_ctrl,
   input  logic        rst,
   dp_ctrl_if.slave    bus,
   output logic        valid_reg,
   output logic [1:0]  addr,
   output logic [15:0] data_in,
   output logic [1:0]  reg_sel,
   output logic        valid_ula,
   output logic [1:0]  instru,
   output logic [15:0] A,
   input  logic [31:0] dp_data_out,
   input  logic        dp_valid_out,
   output logic        busy,
   output logic [7:0]  timeout_cnt
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WRITE  = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYC - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [7:0]  cnt;
   logic        out_of_rst;
   logic        cmd_rdy;
   logic        res_vld;
   logic        cmd_hs;
   logic        res_hs;
   logic        wait_last;
   logic [31:0] res_data_q;
   logic        res_err_q;

   assign cmd_hs    = bus.cmd_valid & cmd_rdy;
   assign res_hs    = res_vld & bus.res_ready;
   assign wait_last = (cnt == TIMEOUT_LAST);

   assign bus.cmd_ready = cmd_rdy;
   assign bus.res_valid = res_vld;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;

   always_ff @(posedge clk_ctrl) begin
      if (rst) begin
         state      <= S_IDLE;
         out_of_rst <= 1'b0;
      end else begin
         state      <= state_nxt;
         out_of_rst <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (cmd_hs) state_nxt = bus.cmd_op ? S_ISSUE : S_WRITE;
         S_WRITE:  state_nxt = S_SETTLE;
         S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_IDLE;
         S_ISSUE:  state_nxt = S_WAIT;
         S_WAIT:   if (dp_valid_out || wait_last) state_nxt = S_RESP;
         S_RESP:   if (res_hs) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // cmd_ready stays low for the first cycle after reset so every output reads 0 under reset
   always_comb begin
      cmd_rdy   = (state == S_IDLE) && out_of_rst;
      valid_reg = (state == S_WRITE);
      valid_ula = (state == S_ISSUE);
      res_vld   = (state == S_RESP);
      busy      = (state != S_IDLE);
   end

   always_ff @(posedge clk_ctrl) begin
      if (rst) begin
         cnt         <= 8'd0;
         addr        <= 2'd0;
         reg_sel     <= 2'd0;
         data_in     <= 16'd0;
         A           <= 16'd0;
         instru      <= 2'd0;
         res_data_q  <= 32'd0;
         res_err_q   <= 1'b0;
         timeout_cnt <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_hs) begin
                  addr    <= bus.cmd_addr;
                  reg_sel <= bus.cmd_addr;
                  data_in <= bus.cmd_data;
                  A       <= bus.cmd_data;
                  instru  <= bus.cmd_instru;
               end
            end
            S_WRITE:  cnt <= 8'd0;
            S_SETTLE: cnt <= cnt + 8'd1;
            S_ISSUE:  cnt <= 8'd0;
            S_WAIT: begin
               // a valid result on the last wait cycle wins over the timeout
               if (dp_valid_out) begin
                  res_data_q <= dp_data_out;
                  res_err_q  <= 1'b0;
               end else if (wait_last) begin
                  res_data_q <= 32'd0;
                  res_err_q  <= 1'b1;
                  if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_dp_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dp_ctrl : scoreboard bench for dp_ctrl with a datapath model    |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module tb_dp_ctrl;
   localparam int SETTLE_CYC = 2;
   localparam int TIMEOUT    = 16;

   logic        clk_ctrl;
   logic        rst;
   logic        valid_reg;
   logic [1:0]  addr;
   logic [15:0] data_in;
   logic [1:0]  reg_sel;
   logic        valid_ula;
   logic [1:0]  instru;
   logic [15:0] A;
   logic [31:0] dp_data_out;
   logic        dp_valid_out;
   logic        busy;
   logic [7:0]  timeout_cnt;

   dp_ctrl_if bus ();

   dp_ctrl #(.SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT)) dut (
      .clk_ctrl     (clk_ctrl),
      .rst          (rst),
      .bus          (bus),
      .valid_reg    (valid_reg),
      .addr         (addr),
      .data_in      (data_in),
      .reg_sel      (reg_sel),
      .valid_ula    (valid_ula),
      .instru       (instru),
      .A            (A),
      .dp_data_out  (dp_data_out),
      .dp_valid_out (dp_valid_out),
      .busy         (busy),
      .timeout_cnt  (timeout_cnt)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   int          cyc    = 0;
   int          dp_delay = 0;
   int          dv_cnt   = 0;
   logic        stray    = 1'b0;
   logic [31:0] pend;
   logic [15:0] mregs  [4];
   logic [15:0] shadow [4];
   logic [32:0] exp_q  [$];

   initial begin
      clk_ctrl = 1'b0;
      forever #5 clk_ctrl = ~clk_ctrl;
   end

   always @(posedge clk_ctrl) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         2'd0:    return {16'h0, a} + {16'h0, b};
         2'd1:    return {16'h0, a} - {16'h0, b};
         2'd2:    return {16'h0, a & b};
         default: return {16'h0, a | b};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk_ctrl);
      #1;
   endtask

   // datapath model: register bank plus a ULA answering dp_delay cycles after valid_ula (0 = never)
   initial begin
      dp_valid_out = 1'b0;
      dp_data_out  = 32'h0;
      for (int i = 0; i < 4; i++) mregs[i] = 16'h0;
      forever begin
         @(posedge clk_ctrl);
         #2;
         dp_valid_out = 1'b0;
         if (stray) begin
            dp_valid_out = 1'b1;
            dp_data_out  = 32'hDEAD_BEEF;
            stray        = 1'b0;
         end
         if (dv_cnt > 0) begin
            dv_cnt--;
            if (dv_cnt == 0) begin
               dp_valid_out = 1'b1;
               dp_data_out  = pend;
            end
         end
         if (valid_reg) mregs[addr] = data_in;
         if (valid_ula) begin
            pend   = alu(instru, A, mregs[reg_sel]);
            dv_cnt = dp_delay;
         end
      end
   end

   always @(negedge clk_ctrl) begin
      if (!rst && bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) check("unexp_res", 64'(bus.res_valid), 64'd0);
         else check("sb_result", 64'({bus.res_err, bus.res_data}), 64'(exp_q.pop_front()));
      end
      if (valid_reg || valid_ula) check("vreg_vula_excl", 64'(valid_reg & valid_ula), 64'd0);
   end

   task automatic check_reset_outs(input string tag);
      check({tag, "_ctl"}, 64'({bus.cmd_ready, bus.res_valid, bus.res_err, busy, valid_reg, valid_ula, timeout_cnt}), 64'd0);
      check({tag, "_dat"}, 64'({bus.res_data, A, data_in, addr, reg_sel, instru}), 64'd0);
   endtask

   task automatic send_cmd(input logic op, input logic [1:0] a, input logic [1:0] ins,
                           input logic [15:0] d, output int acc_cyc);
      int   n   = 0;
      logic acc = 1'b0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = op;
      bus.cmd_addr   = a;
      bus.cmd_instru = ins;
      bus.cmd_data   = d;
      while (!acc && n < 100) begin
         @(negedge clk_ctrl);
         acc = bus.cmd_ready;
         tick();
         n++;
      end
      acc_cyc        = cyc;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 1'($urandom);
      bus.cmd_addr   = 2'($urandom);
      bus.cmd_data   = 16'($urandom);
      check("cmd_accept", 64'(acc), 64'd1);
   endtask

   task automatic run_exec(input logic [1:0] ins, input logic [1:0] ra, input logic [15:0] a,
                           input int d, input bit hold);
      int          acc_c, n, eff, ula_hi;
      logic        seen;
      logic [31:0] first;
      dp_delay = d;
      eff      = (d == 0 || d > TIMEOUT) ? TIMEOUT : d;
      if (d == 0 || d > TIMEOUT) exp_q.push_back({1'b1, 32'h0});
      else exp_q.push_back({1'b0, alu(ins, a, shadow[ra])});
      bus.res_ready = !hold;
      send_cmd(1'b1, ra, ins, a, acc_c);
      n = 0; ula_hi = 0; seen = 1'b0;
      while (n < TIMEOUT + 10) begin
         @(negedge clk_ctrl);
         n++;
         if (bus.res_valid) begin
            seen = 1'b1;
            break;
         end
         if (valid_ula) ula_hi++;
         check("hold_sel", 64'(reg_sel), 64'(ra));
         check("hold_a", 64'(A), 64'(a));
         check("hold_ins", 64'(instru), 64'(ins));
         tick();
      end
      check("res_seen", 64'(seen), 64'd1);
      check("exec_latency", 64'(n), 64'(2 + eff));
      check("vula_pulses", 64'(ula_hi), 64'd1);
      check("resp_sel", 64'(reg_sel), 64'(ra));
      first = bus.res_data;
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk_ctrl);
            check("bp_valid", 64'(bus.res_valid), 64'd1);
            check("bp_data", 64'(bus.res_data), 64'(first));
            check("bp_ready", 64'(bus.cmd_ready), 64'd0);
         end
         tick();
         bus.res_ready = 1'b1;
      end
      tick();
      @(negedge clk_ctrl);
      check("idle_after", 64'({bus.cmd_ready, bus.res_valid, busy}), 64'b100);
      tick();
   endtask

   initial begin
      int t0, t1, n, vr, low, rv;
      rst            = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 1'b0;
      bus.cmd_addr   = 2'd0;
      bus.cmd_instru = 2'd0;
      bus.cmd_data   = 16'h0;
      bus.res_ready  = 1'b1;
      for (int i = 0; i < 4; i++) shadow[i] = 16'h0;

      tick();
      tick();
      @(negedge clk_ctrl);
      check_reset_outs("rst");
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk_ctrl);
      check("rst_ready", 64'({bus.cmd_ready, busy}), 64'b10);
      tick();

      // LOAD r2 = 0x1234
      send_cmd(1'b0, 2'd2, 2'd0, 16'h1234, t0);
      shadow[2] = 16'h1234;
      @(negedge clk_ctrl);
      check("wr_vreg", 64'(valid_reg), 64'd1);
      check("wr_addr", 64'(addr), 64'd2);
      check("wr_data", 64'(data_in), 64'h1234);
      check("wr_busy", 64'(busy), 64'd1);
      vr = 1; low = 1; n = 0;
      tick();
      while (n < 50) begin
         @(negedge clk_ctrl);
         if (bus.cmd_ready) break;
         low++;
         if (valid_reg) vr++;
         tick();
         n++;
      end
      check("ld_ready_low", 64'(low), 64'(1 + SETTLE_CYC));
      check("ld_vreg_pulses", 64'(vr), 64'd1);
      tick();

      // back-to-back LOADs: accept spacing
      send_cmd(1'b0, 2'd1, 2'd0, 16'h0005, t0);
      shadow[1] = 16'h0005;
      send_cmd(1'b0, 2'd3, 2'd0, 16'hA5A5, t1);
      shadow[3] = 16'hA5A5;
      check("ld_spacing", 64'(t1 - t0), 64'(2 + SETTLE_CYC));

      run_exec(2'd0, 2'd1, 16'h0003, 2, 1'b0);
      run_exec(2'd1, 2'd3, 16'h0100, 1, 1'b0);
      run_exec(2'd2, 2'd2, 16'hFF00, 5, 1'b1);
      run_exec(2'd3, 2'd1, 16'h8000, 3, 1'b0);

      // timeout, then a stray dp_valid_out while idle
      run_exec(2'd0, 2'd1, 16'h0007, 0, 1'b0);
      check("tmo_cnt1", 64'(timeout_cnt), 64'd1);
      stray = 1'b1;
      tick();
      tick();
      @(negedge clk_ctrl);
      check("stray_idle", 64'({bus.cmd_ready, bus.res_valid, busy, timeout_cnt}), 64'({3'b100, 8'd1}));
      tick();

      // valid on the last wait cycle beats the timeout; one cycle later loses
      run_exec(2'd0, 2'd1, 16'hFFFF, TIMEOUT, 1'b0);
      check("tmo_cnt_keep", 64'(timeout_cnt), 64'd1);
      run_exec(2'd0, 2'd1, 16'h0001, TIMEOUT + 1, 1'b0);
      check("tmo_cnt2", 64'(timeout_cnt), 64'd2);

      // reset in the middle of WAIT aborts without a result
      dp_delay = 0;
      send_cmd(1'b1, 2'd1, 2'd0, 16'h0003, t0);
      tick();
      tick();
      @(negedge clk_ctrl);
      check("mid_busy", 64'(busy), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk_ctrl);
      check_reset_outs("midrst");
      tick();
      rst = 1'b0;
      rv  = 0;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         @(negedge clk_ctrl);
         if (bus.res_valid) rv++;
         tick();
      end
      check("midrst_nores", 64'(rv), 64'd0);
      @(negedge clk_ctrl);
      check("midrst_ready", 64'({bus.cmd_ready, busy, timeout_cnt}), 64'({2'b10, 8'd0}));
      tick();

      check("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/dp_ctrl.md
Name: dp_ctrl

Overview:
- Command sequencer in front of the datapath (register bank, mux, ULA).
- Accepts one command at a time over a valid/ready interface. A command is either LOAD (write a register) or EXEC (run a ULA operation with A and a selected register).
- Drives the datapath control inputs and waits for the ULA valid_out, with a timeout.
- Returns EXEC results over a valid/ready result interface.

Parameters:
- SETTLE_CYC, 1, idle cycles after a register write before the next command is accepted (1..15).
- TIMEOUT, 16, max cycles in WAIT for dp_valid_out before an error result (2..255).

Ports:
- clk_ctrl  in  1  controller clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
- cmd_op  in  1  0=LOAD, 1=EXEC
- cmd_addr  in  2  LOAD: target register; EXEC: reg_sel
- cmd_instru  in  2  ULA instruction (EXEC only)
- cmd_data  in  16  LOAD: write data; EXEC: operand A
- valid_reg  out  1  to datapath valid_reg
- addr  out  2  to datapath addr
- data_in  out  16  to datapath data_in
- reg_sel  out  2  to datapath reg_sel
- valid_ula  out  1  to datapath valid_ula
- instru  out  2  to datapath instru
- A  out  16  to datapath A
- dp_data_out  in  32  from datapath data_out
- dp_valid_out  in  1  from datapath valid_out
- res_valid  out  1  result valid
- res_ready  in  1  result accepted when res_valid&res_ready
- res_data  out  32  ULA result; 0 on error
- res_err  out  1  1 = timeout
- busy  out  1  state != IDLE
- timeout_cnt  out  8  saturating count of timeouts

Behaviour:
- Single clock clk_ctrl. rst is synchronous, active-high, sampled on the rising edge.
- Reset drives all outputs to 0, state to IDLE and counters to 0. Reset mid-operation aborts the command; no result is produced.
- States: IDLE, WRITE, SETTLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On handshake, latch cmd fields: addr<=cmd_addr, reg_sel<=cmd_addr, data_in<=cmd_data, A<=cmd_data, instru<=cmd_instru.
  - Next state is WRITE if cmd_op=0, ISSUE if cmd_op=1.
- WRITE: valid_reg=1 for exactly one cycle; addr/data_in stable. Next SETTLE.
- SETTLE: count SETTLE_CYC cycles, then IDLE. LOAD produces no result.
- ISSUE:
  - valid_ula=1 for exactly one cycle. A, instru and reg_sel are stable.
  - Wait counter cleared. Next WAIT.
- WAIT:
  - reg_sel, A and instru held stable, because the ULA B operand is combinational through the mux.
  - dp_valid_out=1 latches res_data<=dp_data_out, res_err<=0, then RESP.
  - Otherwise the counter increments. When counter==TIMEOUT-1 without valid: res_data<=0, res_err<=1, timeout_cnt increments (saturates at 255), then RESP.
  - dp_valid_out has priority over timeout on the same cycle.
- RESP:
  - res_valid=1; res_data/res_err held until res_ready. On handshake go to IDLE.
  - Earliest next cmd_ready is the cycle after the result handshake.
- dp_valid_out in any state other than WAIT (including the ISSUE cycle) is ignored.
- valid_reg and valid_ula are never high together and are never high outside WRITE/ISSUE.
- Latency:
  - LOAD: accept, then 1 write cycle, then SETTLE_CYC cycles, then ready. The next accept comes 2+SETTLE_CYC cycles after the previous one.
  - EXEC: res_valid rises the cycle after the dp_valid_out sample.
- busy is registered with state and equals (state!=IDLE).
- cmd inputs are ignored while cmd_ready=0. res_ready is ignored while res_valid=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → all outputs 0, cmd_ready=1 the cycle after rst falls, busy=0.
- LOAD: cmd_op=0, addr=2, data=0x1234 → valid_reg high exactly 1 cycle with addr=2, data_in=0x1234; cmd_ready low for 1+SETTLE_CYC cycles; no res_valid.
- EXEC: LOAD r1=0x0005, then EXEC instru=0, A=0x0003, addr=1; model returns dp_valid_out after 2 cycles with 0x00000008 → res_valid with res_data=0x00000008, res_err=0. reg_sel=1 held from ISSUE to RESP.
- Backpressure: hold res_ready=0 for 5 cycles → res_valid/res_data stable, cmd_ready=0 throughout; release → IDLE next cycle.
- Timeout: EXEC with dp_valid_out never asserted → res_valid after TIMEOUT WAIT cycles, res_err=1, res_data=0, timeout_cnt=1. Stray dp_valid_out in IDLE → no effect.
- Reset mid-WAIT: assert rst during WAIT → IDLE, no res_valid, counters 0. Simultaneous dp_valid_out and final timeout cycle → res_err=0 with the data.
